cvs_channel_scheduler: RTL and testbench

Time-slot round-robin scheduler that shares the single clock-output path of simple_fpga_cvs among NUM_CHANNELS requesting clock channels. It grants one channel at a time for a fixed slot, inserts a guard gap between slots, and exposes the granted channel as both a one-hot vector and an index. It sits between the channel request logic and the output mux that drives out[4:0].

---
 rtl/cvs_sched_pkg.sv | 18 +
 rtl/cvs_rr_picker.sv | 30 +++
 rtl/cvs_channel_scheduler.sv | 151 +++++++++++++++
 tb/tb_cvs_channel_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvs_sched_pkg.sv
// Shared types and helpers for the CVS channel scheduler.
package cvs_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam int CVS_NUM_CHANNELS = 5;
  localparam int CVS_IDX_W        = $clog2(CVS_NUM_CHANNELS);
  localparam int CVS_MAX_IDX_W    = 4;

  function automatic logic [15:0] onehot_from_idx(input logic [CVS_MAX_IDX_W-1:0] idx);
    onehot_from_idx = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/cvs_rr_picker.sv
// Combinational round-robin picker: first requester searching upward from ptr_i+1 with wrap.
module cvs_rr_picker #(
  parameter int NUM_CHANNELS = 5,
  parameter int IDX_W        = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req_i,
  input  logic [IDX_W-1:0]        ptr_i,
  output logic                    found_o,
  output logic [IDX_W-1:0]        winner_o
);

  int cand;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    found_o  = 1'b0;
    winner_o = {IDX_W{1'b0}};
    cand     = 0;
    for (int off = NUM_CHANNELS; off >= 1; off--) begin
      cand = int'(ptr_i) + off;
      cand = (cand >= NUM_CHANNELS) ? (cand - NUM_CHANNELS) : cand;
      if (req_i[cand]) begin
        found_o  = 1'b1;
        winner_o = IDX_W'(cand);
      end else begin
      end
    end
  end

endmodule

// File: rtl/cvs_channel_scheduler.sv
// Time-slot round-robin scheduler for the shared CVS clock-output path.
// Optional per-channel grant counters are enabled with the CVS_SCHED_STATS_EN macro.
module cvs_channel_scheduler
  import cvs_sched_pkg::*;
#(
  parameter int NUM_CHANNELS = CVS_NUM_CHANNELS,
  parameter int SLOT_CYCLES  = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_CHANNELS-1:0]         req,
  output logic [NUM_CHANNELS-1:0]         grant,
  output logic                            grant_valid,
  output logic [$clog2(NUM_CHANNELS)-1:0] grant_idx,
  output logic                            slot_done
`ifdef CVS_SCHED_STATS_EN
  ,
  output logic [NUM_CHANNELS*16-1:0]      grant_count
`endif
);

  localparam int IDX_W  = $clog2(NUM_CHANNELS);
  localparam int SLOT_W = $clog2(SLOT_CYCLES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(GAP_CYCLES - 1);

  sched_state_t            state_q, state_d;
  logic [NUM_CHANNELS-1:0] grant_q, grant_d;
  logic                    valid_q, valid_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    done_q, done_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [7:0]              gap_q, gap_d;
  logic                    found_s;
  logic [IDX_W-1:0]        winner_s;
  logic                    load_s;

  cvs_rr_picker #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .IDX_W        (IDX_W)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .found_o  (found_s),
    .winner_o (winner_s)
  );

  // Next-state logic; a new grant is loaded from IDLE or from the last gap cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    gap_d   = gap_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        load_s = enable && found_s;
      end
      GRANT: begin
        if ((slot_q == SLOT_LAST) || !req[idx_q] || !enable) begin
          grant_d = {NUM_CHANNELS{1'b0}};
          valid_d = 1'b0;
          idx_d   = {IDX_W{1'b0}};
          done_d  = 1'b1;
          gap_d   = 8'd0;
          state_d = GAP;
        end else begin
          slot_d = slot_q + {{(SLOT_W-1){1'b0}}, 1'b1};
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          load_s  = enable && found_s;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {NUM_CHANNELS{1'b0}};
        valid_d = 1'b0;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
    if (load_s) begin
      grant_d = NUM_CHANNELS'(onehot_from_idx(CVS_MAX_IDX_W'(winner_s)));
      valid_d = 1'b1;
      idx_d   = winner_s;
      ptr_d   = winner_s;
      slot_d  = {SLOT_W{1'b0}};
      state_d = GRANT;
    end else begin
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= {NUM_CHANNELS{1'b0}};
      valid_q <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      done_q  <= 1'b0;
      ptr_q   <= IDX_W'(NUM_CHANNELS - 1);
      slot_q  <= {SLOT_W{1'b0}};
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      gap_q   <= gap_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
  assign slot_done   = done_q;

`ifdef CVS_SCHED_STATS_EN
  logic [15:0] cnt_q [NUM_CHANNELS];

  // Saturating per-channel grant counters, bumped on the grant edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cnt_q[c] <= 16'd0;
      end
    end else if (load_s && (cnt_q[winner_s] != 16'hFFFF)) begin
      cnt_q[winner_s] <= cnt_q[winner_s] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_cnt
    assign grant_count[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_cvs_channel_scheduler.sv
// Self-checking bench for cvs_channel_scheduler against a slot/gap reference model.
module tb_cvs_channel_scheduler;

  localparam int N    = 5;
  localparam int SLOT = 16;
  localparam int GAP  = 2;
  localparam int IW   = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          slot_done;
`ifdef CVS_SCHED_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  int tests  = 0;
  int failed = 0;

  // Reference model: current owner (-1 = none), cycles owned, gap cycles left.
  int m_owner, m_age, m_gap, m_last, m_done;
  int m_cnt [N];

  cvs_channel_scheduler #(
    .NUM_CHANNELS (N),
    .SLOT_CYCLES  (SLOT),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .slot_done   (slot_done)
`ifdef CVS_SCHED_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_step();
    int c;
    if (reset) begin
      m_owner = -1; m_age = 0; m_gap = 0; m_last = N - 1; m_done = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      m_done = 0;
      if (m_owner >= 0) begin
        if (m_age == SLOT || !req[m_owner] || !enable) begin
          m_owner = -1; m_done = 1; m_gap = GAP;
        end else begin
          m_age++;
        end
      end else if (m_gap > 1) begin
        m_gap--;
      end else begin
        m_gap = 0;
        if (enable && req != '0) begin
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (m_owner < 0 && req[c]) begin
              m_owner = c; m_last = c; m_age = 1;
              if (m_cnt[c] < 65535) m_cnt[c]++;
            end
          end
        end
      end
    end
  endtask

  function automatic logic [N+IW+1:0] model_out();
    logic [N-1:0] g;
    g = (m_owner >= 0) ? (5'b00001 << m_owner) : 5'b00000;
    return {g, (m_owner >= 0), (m_owner >= 0) ? 3'(m_owner) : 3'd0, (m_done != 0)};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; req = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({grant, grant_valid, grant_idx, slot_done} !== 10'd0) begin
      failed++;
      $display("FAIL reset got %b exp %b", {grant, grant_valid, grant_idx, slot_done}, 10'd0);
    end
  endtask

  task automatic test_single();
    int gcyc = 0;
    do_reset();
    enable = 1'b1; req = 5'b00001;
    tick();
    tests++;
    if (grant !== 5'b00001) begin
      failed++; $display("FAIL single_latency got %b exp %b", grant, 5'b00001);
    end
    for (int i = 0; i < 40; i++) begin
      if (i < 16 && grant_valid) gcyc++;
      tests++;
      if ({grant, grant_valid, grant_idx, slot_done} !== model_out()) begin
        failed++;
        $display("FAIL single cyc%0d got %b exp %b", i, {grant, grant_valid, grant_idx, slot_done}, model_out());
      end
      tick();
    end
    tests++;
    if (gcyc != SLOT) begin
      failed++; $display("FAIL single_slot_len got %0d exp %0d", gcyc, SLOT);
    end
  endtask

  task automatic test_all_req();
    int seq[$];
    logic prev_v = 1'b0;
    do_reset();
    enable = 1'b1; req = 5'b11111;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (grant_valid && !prev_v) seq.push_back(int'(grant_idx));
      prev_v = grant_valid;
      tests++;
      if ({grant, grant_valid, grant_idx, slot_done} !== model_out()) begin
        failed++;
        $display("FAIL all_req cyc%0d got %b exp %b", i, {grant, grant_valid, grant_idx, slot_done}, model_out());
      end
    end
    tests++;
    if (seq.size() < 6) begin
      failed++; $display("FAIL all_req_count got %0d exp >=6", seq.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (seq[k] != k % N) begin
          failed++; $display("FAIL all_req_order slot%0d got %0d exp %0d", k, seq[k], k % N);
        end
      end
    end
  endtask

  task automatic test_early_release();
    int gcyc = 0;
    do_reset();
    enable = 1'b1; req = 5'b00100;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (grant_valid) gcyc++;
      if (i == 5) req = 5'b00000;
      tests++;
      if ({grant, grant_valid, grant_idx, slot_done} !== model_out()) begin
        failed++;
        $display("FAIL early cyc%0d got %b exp %b", i, {grant, grant_valid, grant_idx, slot_done}, model_out());
      end
    end
    tests++;
    if (gcyc != 6) begin
      failed++; $display("FAIL early_len got %0d exp 6", gcyc);
    end
  endtask

  task automatic test_enable_drop();
    int gcyc = 0;
    do_reset();
    enable = 1'b1; req = 5'b11111;
    tick(); tick(); tick();
    enable = 1'b0;
    tick();
    tests++;
    if ({grant_valid, slot_done} !== 2'b01) begin
      failed++; $display("FAIL en_drop_release got %b exp 01", {grant_valid, slot_done});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant_valid) gcyc++;
      tests++;
      if ({grant, grant_valid, grant_idx, slot_done} !== model_out()) begin
        failed++;
        $display("FAIL en_drop cyc%0d got %b exp %b", i, {grant, grant_valid, grant_idx, slot_done}, model_out());
      end
    end
    tests++;
    if (gcyc != 0) begin
      failed++; $display("FAIL en_drop_hold got %0d grant cycles exp 0", gcyc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1; req = 5'b01000;
    tick(); tick(); tick(); tick();
    tests++;
    if ({grant_valid, grant_idx} !== 4'b1011) begin
      failed++; $display("FAIL rst_mid_owner got %b exp 1011", {grant_valid, grant_idx});
    end
    reset = 1'b1;
    tick();
    tests++;
    if ({grant, grant_valid, slot_done} !== 7'd0) begin
      failed++; $display("FAIL rst_mid_clear got %b exp 0", {grant, grant_valid, slot_done});
    end
    reset = 1'b0; req = 5'b11111;
    tick();
    tests++;
    if ({grant, grant_valid, grant_idx} !== 9'b00001_1_000) begin
      failed++; $display("FAIL rst_mid_first got %b exp 000011000", {grant, grant_valid, grant_idx});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) req = 5'($urandom);
      tick();
      tests++;
      if ({grant, grant_valid, grant_idx, slot_done} !== model_out()) begin
        failed++;
        $display("FAIL random cyc%0d got %b exp %b", i, {grant, grant_valid, grant_idx, slot_done}, model_out());
      end
    end
    reset = 1'b0;
  endtask

`ifdef CVS_SCHED_STATS_EN
  task automatic test_stats();
    int starts = 0;
    logic prev_v = 1'b0;
    do_reset();
    enable = 1'b1; req = 5'b10010;
    for (int i = 0; i < 400 && starts < 10; i++) begin
      tick();
      if (grant_valid && !prev_v) starts++;
      prev_v = grant_valid;
    end
    tests++;
    if (starts != 10) begin
      failed++; $display("FAIL stats_slots got %0d exp 10", starts);
    end
    for (int c = 0; c < N; c++) begin
      tests++;
      if (grant_count[c*16 +: 16] !== 16'(m_cnt[c]) || m_cnt[c] != ((c == 1 || c == 4) ? 5 : 0)) begin
        failed++;
        $display("FAIL stats ch%0d got %0d exp %0d", c, grant_count[c*16 +: 16], (c == 1 || c == 4) ? 5 : 0);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b0; req = '0;
    m_owner = -1; m_age = 0; m_gap = 0; m_last = N - 1; m_done = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    test_reset();
    test_single();
    test_all_req();
    test_early_release();
    test_enable_drop();
    test_reset_mid();
    test_random();
`ifdef CVS_SCHED_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
